// File: rtl/fft_pkg.sv
// Shared constants for the FFT result serializer.
// State codes, per-point byte count and frame length. The frame layout depends
// on the FFT_OUT_MAG_EN macro: when it is defined, each point carries a third
// magnitude byte after the real and imaginary bytes.
package fft_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned IDX_W   = 4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD     = 3'd1;
  localparam logic [STATE_W-1:0] ST_PRESENT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_REL = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;

`ifdef FFT_OUT_MAG_EN
  localparam int unsigned BYTES_PER_POINT = 3;
`else
  localparam int unsigned BYTES_PER_POINT = 2;
`endif

  // Width of the within-point component counter (re / im / mag).
  localparam int unsigned COMP_W = (BYTES_PER_POINT > 2) ? 2 : 1;

  // Bytes in one frame for a given number of points.
  function automatic int unsigned frame_bytes(input int unsigned n_points);
    return n_points * BYTES_PER_POINT;
  endfunction

endpackage

// File: rtl/fft_ack_sync.sv
// Synchronizer for the asynchronous host acknowledge.
// Ports: clk, rst_n (sync, active-low), ena (holds the chain when low),
//        async_in (raw pin), sync_out (synchronized level).
module fft_ack_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  // Shift chain; bit 0 is the metastability-exposed capture flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (ena) begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/fft_result_serializer.sv
// Serializes a snapshot of the FFT core's complex results onto an 8-bit port
// under a host-driven 4-phase valid/ack handshake.
// Ports:
//   clk, rst_n (sync, active-low), ena (low freezes every register)
//   start               1-cycle pulse, results valid, begin a frame
//   result_re/result_im point k at [k*DATA_W +: DATA_W]
//   host_ack            asynchronous host acknowledge
//   data_out, out_valid current byte and its strobe
//   busy, done, byte_idx frame status and index of the byte on data_out
// Build option: FFT_OUT_MAG_EN appends |re|+|im| (saturated) after each point.
module fft_result_serializer
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned N_POINTS    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic [N_POINTS*DATA_W-1:0]   result_re,
  input  logic [N_POINTS*DATA_W-1:0]   result_im,
  input  logic                         host_ack,
  output logic [7:0]                   data_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   byte_idx
);

  localparam int unsigned VEC_W = N_POINTS * DATA_W;
  localparam int unsigned PT_W  = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

  logic                 ack_s;
  logic [STATE_W-1:0]   state, next_state;
  logic [VEC_W-1:0]     shadow_re, shadow_re_nxt;
  logic [VEC_W-1:0]     shadow_im, shadow_im_nxt;
  logic [PT_W-1:0]      pt, pt_nxt;
  logic [COMP_W-1:0]    comp, comp_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [7:0]           data_out_nxt;
  logic                 out_valid_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic [3:0]           byte_idx_nxt;
  logic                 last_byte;
  logic [DATA_W-1:0]    sel_re, sel_im;
  logic [7:0]           re_b, im_b, cur_byte;

  fft_ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .async_in (host_ack),
    .sync_out (ack_s)
  );

  // Components of the point currently being streamed.
  assign sel_re = shadow_re[32'(pt) * DATA_W +: DATA_W];
  assign sel_im = shadow_im[32'(pt) * DATA_W +: DATA_W];

  // Map a DATA_W component onto one byte: keep the top 8 bits, or sign-extend.
  if (DATA_W >= 8) begin : g_byte_trunc
    assign re_b = sel_re[DATA_W-1 -: 8];
    assign im_b = sel_im[DATA_W-1 -: 8];
  end else begin : g_byte_sext
    assign re_b = {{(8-DATA_W){sel_re[DATA_W-1]}}, sel_re};
    assign im_b = {{(8-DATA_W){sel_im[DATA_W-1]}}, sel_im};
  end

`ifdef FFT_OUT_MAG_EN
  logic [7:0] abs_re, abs_im, mag;
  logic [8:0] mag_sum;

  // |x| of 8'h80 is 128, which still fits unsigned in 8 bits.
  assign abs_re  = re_b[7] ? 8'(~re_b + 8'd1) : re_b;
  assign abs_im  = im_b[7] ? 8'(~im_b + 8'd1) : im_b;
  assign mag_sum = {1'b0, abs_re} + {1'b0, abs_im};
  assign mag     = mag_sum[8] ? 8'hFF : mag_sum[7:0];

  always_comb begin
    cur_byte = re_b;
    if (comp == COMP_W'(1))      cur_byte = im_b;
    else if (comp == COMP_W'(2)) cur_byte = mag;
  end
`else
  assign cur_byte = comp[0] ? im_b : re_b;
`endif

  assign last_byte = (idx == IDX_W'(frame_bytes(N_POINTS) - 1));

  // Next-state and next-output logic.
  always_comb begin
    next_state    = state;
    shadow_re_nxt = shadow_re;
    shadow_im_nxt = shadow_im;
    pt_nxt        = pt;
    comp_nxt      = comp;
    idx_nxt       = idx;
    data_out_nxt  = data_out;
    byte_idx_nxt  = byte_idx;

    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        shadow_re_nxt = result_re;
        shadow_im_nxt = result_im;
        pt_nxt        = '0;
        comp_nxt      = '0;
        idx_nxt       = '0;
        byte_idx_nxt  = '0;
        next_state    = ST_PRESENT;
      end
      ST_PRESENT: begin
        data_out_nxt = cur_byte;
        byte_idx_nxt = idx;
        if (ack_s) next_state = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!ack_s) begin
          if (last_byte) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_PRESENT;
            idx_nxt    = idx + IDX_W'(1);
            if (comp == COMP_W'(BYTES_PER_POINT - 1)) begin
              comp_nxt = '0;
              pt_nxt   = pt + PT_W'(1);
            end else begin
              comp_nxt = comp + COMP_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    // Valid only once the byte has been registered and the host has not yet acked.
    out_valid_nxt = (state == ST_PRESENT) && (next_state == ST_PRESENT);
    busy_nxt      = (next_state == ST_LOAD) || (next_state == ST_PRESENT) ||
                    (next_state == ST_WAIT_REL);
    done_nxt      = (next_state == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shadow_re <= '0;
      shadow_im <= '0;
      pt        <= '0;
      comp      <= '0;
      idx       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_idx  <= '0;
    end else if (ena) begin
      state     <= next_state;
      shadow_re <= shadow_re_nxt;
      shadow_im <= shadow_im_nxt;
      pt        <= pt_nxt;
      comp      <= comp_nxt;
      idx       <= idx_nxt;
      data_out  <= data_out_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      byte_idx  <= byte_idx_nxt;
    end
  end

endmodule
